// File: rtl/cmp_lock_detector.sv
// Lock detector for a magnitude comparator's one-hot L/E/G flags: saturating outcome
// counters, a sticky one-hot error flag and an IDLE/ACQ/LOCKED settle FSM.
module cmp_lock_detector #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             L,
  input  logic             E,
  input  logic             G,
  input  logic             clr,
  output logic             locked,
  output logic             lock_pulse,
  output logic             unlock_pulse,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic             err
);

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_p1;
  logic [RUN_W-1:0] run_p1;
  logic [RUN_W-1:0] miss_p1;

  logic             onehot_p0;
  logic             good_p0;
  logic             bad_p0;
  logic [RUN_W:0]   run_inc_p0;
  logic [RUN_W:0]   miss_inc_p0;
  logic             lock_hit_p0;
  logic             miss_hit_p0;

  // p0: classify the incoming sample and precompute the streak thresholds
  always_comb begin
    onehot_p0   = ({L, E, G} == 3'b100) || ({L, E, G} == 3'b010) || ({L, E, G} == 3'b001);
    good_p0     = in_valid && onehot_p0;
    bad_p0      = in_valid && !onehot_p0;
    run_inc_p0  = {1'b0, run_p1} + (RUN_W+1)'(1);
    miss_inc_p0 = {1'b0, miss_p1} + (RUN_W+1)'(1);
    lock_hit_p0 = (run_inc_p0 == (RUN_W+1)'(LOCK_CNT));
    miss_hit_p0 = (miss_inc_p0 == (RUN_W+1)'(MISS_MAX));
  end

  // p1: registered counters, FSM and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1     <= IDLE;
      run_p1       <= '0;
      miss_p1      <= '0;
      locked       <= 1'b0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
      lt_cnt       <= '0;
      eq_cnt       <= '0;
      gt_cnt       <= '0;
      err          <= 1'b0;
    end else begin
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
      if (clr) begin
        // Clear silently discards any concurrent sample and never pulses
        state_p1 <= IDLE;
        run_p1   <= '0;
        miss_p1  <= '0;
        locked   <= 1'b0;
        lt_cnt   <= '0;
        eq_cnt   <= '0;
        gt_cnt   <= '0;
        err      <= 1'b0;
      end else begin
        if (bad_p0) begin
          err <= 1'b1;
        end
        if (good_p0) begin
          if (L) lt_cnt <= sat_inc(lt_cnt);
          if (E) eq_cnt <= sat_inc(eq_cnt);
          if (G) gt_cnt <= sat_inc(gt_cnt);
          case (state_p1)
            IDLE: begin
              if (E) begin
                run_p1 <= RUN_W'(1);
                if (LOCK_CNT == 1) begin
                  state_p1   <= LOCKED;
                  miss_p1    <= '0;
                  locked     <= 1'b1;
                  lock_pulse <= 1'b1;
                end else begin
                  state_p1 <= ACQ;
                end
              end
            end
            ACQ: begin
              if (E) begin
                if (lock_hit_p0) begin
                  state_p1   <= LOCKED;
                  miss_p1    <= '0;
                  locked     <= 1'b1;
                  lock_pulse <= 1'b1;
                end else begin
                  run_p1 <= run_inc_p0[RUN_W-1:0];
                end
              end else begin
                state_p1 <= IDLE;
                run_p1   <= '0;
              end
            end
            LOCKED: begin
              if (E) begin
                miss_p1 <= '0;
              end else if (miss_hit_p0) begin
                state_p1     <= IDLE;
                run_p1       <= '0;
                miss_p1      <= '0;
                locked       <= 1'b0;
                unlock_pulse <= 1'b1;
              end else begin
                miss_p1 <= miss_inc_p0[RUN_W-1:0];
              end
            end
            default: begin
              state_p1 <= IDLE;
              run_p1   <= '0;
              miss_p1  <= '0;
              locked   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(lock_pulse && unlock_pulse));

  a_locked_state: assert property (@(posedge clk) disable iff (!rst_n)
    locked == (state_p1 == LOCKED));

endmodule

// File: tb/tb_cmp_lock_detector.sv
// Scoreboard bench for cmp_lock_detector: a streak-based reference model queues the
// expected outputs per clock, a monitor pops and compares; directed scenarios then random.
module tb_cmp_lock_detector;

  localparam int CNT_W    = 4;
  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 2;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             L = 1'b0, E = 1'b0, G = 1'b0;
  logic             clr = 1'b0;
  logic             locked, lock_pulse, unlock_pulse, err;
  logic [CNT_W-1:0] lt_cnt, eq_cnt, gt_cnt;

  cmp_lock_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .L(L), .E(E), .G(G), .clr(clr),
    .locked(locked), .lock_pulse(lock_pulse), .unlock_pulse(unlock_pulse),
    .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lk, lp, up, er, lt, eq, gt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: counts and streaks of good samples
  int m_lt, m_eq, m_gt, m_err, m_locked, e_streak, ne_streak;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_locked = 0;
      e_streak = 0; ne_streak = 0;
      q.delete();
    end else begin
      exp_t x;
      x.lp = 0;
      x.up = 0;
      if (clr) begin
        m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_locked = 0;
        e_streak = 0; ne_streak = 0;
      end else if (in_valid) begin
        if ($countones({L, E, G}) != 1) begin
          m_err = 1;
        end else begin
          if (L) m_lt = (m_lt + 1 > MAXC) ? MAXC : m_lt + 1;
          if (E) m_eq = (m_eq + 1 > MAXC) ? MAXC : m_eq + 1;
          if (G) m_gt = (m_gt + 1 > MAXC) ? MAXC : m_gt + 1;
          if (E) begin e_streak++; ne_streak = 0; end
          else   begin ne_streak++; e_streak = 0; end
          if (!m_locked && e_streak >= LOCK_CNT) begin
            m_locked = 1; x.lp = 1;
          end else if (m_locked && ne_streak >= MISS_MAX) begin
            m_locked = 0; x.up = 1;
          end
        end
      end
      x.lk = m_locked; x.er = m_err; x.lt = m_lt; x.eq = m_eq; x.gt = m_gt;
      q.push_back(x);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("sb_locked", 32'(locked), 32'(x.lk));
      chk("sb_lock_pulse", 32'(lock_pulse), 32'(x.lp));
      chk("sb_unlock_pulse", 32'(unlock_pulse), 32'(x.up));
      chk("sb_err", 32'(err), 32'(x.er));
      chk("sb_lt_cnt", 32'(lt_cnt), 32'(x.lt));
      chk("sb_eq_cnt", 32'(eq_cnt), 32'(x.eq));
      chk("sb_gt_cnt", 32'(gt_cnt), 32'(x.gt));
    end
  end

  task automatic drive(input logic v, input logic l, input logic e, input logic g, input logic c);
    @(negedge clk);
    in_valid = v; L = l; E = e; G = g; clr = c;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic e_n(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 1, 0, 0);
  endtask

  logic [2:0] bad_pat [5];
  logic [2:0] pat;
  logic       rv, rc;
  int         r;

  initial begin
    bad_pat[0] = 3'b000; bad_pat[1] = 3'b011; bad_pat[2] = 3'b101;
    bad_pat[3] = 3'b110; bad_pat[4] = 3'b111;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_eq_cnt", 32'(eq_cnt), 0);
    chk("rst_err", 32'(err), 0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 1: four E samples lock
    e_n(4); settle();
    chk("t1_locked", 32'(locked), 1);
    chk("t1_lock_pulse", 32'(lock_pulse), 1);
    chk("t1_eq_cnt", 32'(eq_cnt), 4);

    // 2: G inside the acquire run restarts it
    drive(0, 0, 0, 0, 1);
    e_n(3); drive(1, 0, 0, 1, 0); settle();
    chk("t2_no_lock_at_g", 32'(locked), 0);
    e_n(4); settle();
    chk("t2_locked", 32'(locked), 1);
    chk("t2_lock_pulse", 32'(lock_pulse), 1);
    chk("t2_eq_cnt", 32'(eq_cnt), 7);
    chk("t2_gt_cnt", 32'(gt_cnt), 1);

    // 3: L,E,L,L from lock
    drive(1, 1, 0, 0, 0); settle();
    chk("t3_first_l_locked", 32'(locked), 1);
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0); settle();
    chk("t3_one_miss_locked", 32'(locked), 1);
    drive(1, 1, 0, 0, 0); settle();
    chk("t3_unlock_pulse", 32'(unlock_pulse), 1);
    chk("t3_unlocked", 32'(locked), 0);

    // 4: non-one-hot sample during acquire
    drive(0, 0, 0, 0, 1);
    e_n(2); drive(1, 1, 1, 0, 0); settle();
    chk("t4_err", 32'(err), 1);
    chk("t4_eq_hold", 32'(eq_cnt), 2);
    chk("t4_lt_hold", 32'(lt_cnt), 0);
    e_n(2); settle();
    chk("t4_run_kept_lock", 32'(locked), 1);
    drive(0, 0, 0, 0, 1); settle();
    chk("t4_clr_err", 32'(err), 0);

    // 5: saturation of a 4-bit counter
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0);
    settle();
    chk("t5_lt_sat", 32'(lt_cnt), 15);
    drive(1, 1, 0, 0, 0); settle();
    chk("t5_lt_hold", 32'(lt_cnt), 15);

    // 6: clr beats a simultaneous E while locked; then async reset mid-lock
    drive(0, 0, 0, 0, 1);
    e_n(4); drive(1, 0, 1, 0, 1); settle();
    chk("t6_clr_locked", 32'(locked), 0);
    chk("t6_clr_no_unlock", 32'(unlock_pulse), 0);
    chk("t6_clr_eq", 32'(eq_cnt), 0);
    drive(1, 1, 1, 1, 0);
    e_n(4); drive(0, 0, 0, 0, 0); settle();
    chk("t6_pre_rst_locked", 32'(locked), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_locked", 32'(locked), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_eq", 32'(eq_cnt), 0);
    chk("t6_rst_unlock", 32'(unlock_pulse), 0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Random traffic, biased toward E so locks and unlocks both occur
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      rc = ($urandom_range(0, 63) == 0);
      rv = ($urandom_range(0, 7) != 0);
      if (r < 8)       pat = bad_pat[$urandom_range(0, 4)];
      else if (r < 62) pat = 3'b010;
      else if (r < 81) pat = 3'b100;
      else             pat = 3'b001;
      drive(rv, pat[2], pat[1], pat[0], rc);
    end
    drive(0, 0, 0, 0, 0);
    settle();
    chk("sb_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
